// File: rtl/inst_dispatcher.sv
// Instruction dispatcher: fetches one instruction at a time from instruction memory and issues it
// to the addressed processor cache, waiting for completion before fetching the next.
module inst_dispatcher #(
  parameter int unsigned MAX_INSTR = 5,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic       start_i,
  output logic       send_o,
  input  logic [1:0] in_proc_i,
  input  logic [1:0] in_opcode_i,
  input  logic [3:0] in_tag_i,
  input  logic [7:0] in_data_i,
  output logic [2:0] req_valid_o,
  output logic [1:0] req_op_o,
  output logic [3:0] req_tag_o,
  output logic [7:0] req_data_o,
  input  logic       req_ack_i,
  input  logic       req_done_i,
  output logic       busy_o,
  output logic       halted_o,
  output logic       error_o,
  output logic [2:0] instr_count_o
);

  // state     | meaning
  // IDLE      | waiting for start
  // SEND      | fetch strobe to instruction memory
  // WAIT_MEM  | memory output settling; latch fields on exit
  // DECODE    | classify latched instruction
  // ISSUE     | request held until the cache acks
  // WAIT_DONE | waiting for the cache to finish, bounded by the timeout counter
  // NEXT      | fetch again or stop at the instruction limit
  // HALT      | run finished; only reset leaves this state
  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_MEM, DECODE, ISSUE, WAIT_DONE, NEXT, HALT
  } state_e;

  localparam logic [2:0] MAX_C = 3'(MAX_INSTR);
  localparam logic [3:0] TMO_C = 4'(TIMEOUT);

  state_e     state_q, state_d;
  logic       send_q, send_d;
  logic [1:0] proc_q, proc_d;
  logic [2:0] valid_q, valid_d;
  logic [1:0] op_q, op_d;
  logic [3:0] tag_q, tag_d;
  logic [7:0] data_q, data_d;
  logic       busy_q, busy_d;
  logic       halted_q, halted_d;
  logic       err_q, err_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] tmo_q, tmo_d;
  logic [2:0] cnt_inc;

  // Completed-instruction count saturates rather than wrapping.
  assign cnt_inc = (cnt_q == MAX_C) ? cnt_q : cnt_q + 3'd1;

  always_comb begin
    state_d = state_q;
    proc_d  = proc_q;
    valid_d = valid_q;
    op_d    = op_q;
    tag_d   = tag_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SEND;
          err_d   = 1'b0;
          cnt_d   = 3'd0;
        end
      end
      SEND: state_d = WAIT_MEM;
      WAIT_MEM: begin
        proc_d  = in_proc_i;
        op_d    = in_opcode_i;
        tag_d   = in_tag_i;
        data_d  = in_data_i;
        state_d = DECODE;
      end
      DECODE: begin
        if (proc_q == 2'b11 && op_q == 2'b11) begin
          state_d = HALT;
        end else if (op_q == 2'b10 || proc_q == 2'b11) begin
          err_d   = 1'b1;
          cnt_d   = cnt_inc;
          state_d = NEXT;
        end else begin
          valid_d = 3'b001 << proc_q;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (req_ack_i) begin
          valid_d = 3'b000;
          tmo_d   = 4'd0;
          if (req_done_i) begin
            cnt_d   = cnt_inc;
            state_d = NEXT;
          end else begin
            state_d = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (req_done_i) begin
          cnt_d   = cnt_inc;
          state_d = NEXT;
        end else if (tmo_q == TMO_C - 4'd1) begin
          tmo_d   = TMO_C;
          err_d   = 1'b1;
          cnt_d   = cnt_inc;
          state_d = NEXT;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      NEXT:    state_d = (cnt_q == MAX_C) ? HALT : SEND;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    // Status outputs are registered from the next state so they align with it.
    send_d   = (state_d == SEND);
    busy_d   = (state_d != IDLE) && (state_d != HALT);
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      send_q   <= 1'b0;
      proc_q   <= 2'b00;
      valid_q  <= 3'b000;
      op_q     <= 2'b00;
      tag_q    <= 4'd0;
      data_q   <= 8'd0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 3'd0;
      tmo_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      send_q   <= send_d;
      proc_q   <= proc_d;
      valid_q  <= valid_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  assign send_o        = send_q;
  assign req_valid_o   = valid_q;
  assign req_op_o      = op_q;
  assign req_tag_o     = tag_q;
  assign req_data_o    = data_q;
  assign busy_o        = busy_q;
  assign halted_o      = halted_q;
  assign error_o       = err_q;
  assign instr_count_o = cnt_q;

endmodule
